// File: rtl/nms_pkg.sv
// Shared definitions for the FAST9 non-maximum-suppression stage:
// default frame geometry, controller state encoding and adjScore slot layout.
package nms_pkg;

   localparam int IMG_W_DEF = 181;
   localparam int IMG_H_DEF = 181;
   localparam int AW_DEF    = 15;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } nms_state_t;

   // Byte slots inside the 64-bit adjScore bus (slot 7 is the MSB byte).
   localparam int ADJ_TL = 7;
   localparam int ADJ_T  = 6;
   localparam int ADJ_TR = 5;
   localparam int ADJ_L  = 4;
   localparam int ADJ_R  = 3;
   localparam int ADJ_BL = 2;
   localparam int ADJ_B  = 1;
   localparam int ADJ_BR = 0;

endpackage

// File: rtl/NMS_Datapath.sv
// Combinational NMS verdict: the centre is a corner when it is non-zero and
// >= every one of its eight neighbours. outAddr converts the bottom-right
// pixel address into the centre address (one row and one column back).
module NMS_Datapath #(
   parameter int IMG_W = 181,
   parameter int AW    = 15
) (
   input  logic [7:0]    refScore,
   input  logic [63:0]   adjScore,
   input  logic [AW-1:0] refAddr,
   output logic [7:0]    outPixel,
   output logic [AW-1:0] outAddr
);

   logic w_ge;

   // Compare the centre against all eight neighbours; non-corners drive 00.
   always_comb begin
      w_ge = 1'b1;
      for (int i = 0; i < 8; i++)
         if (refScore < adjScore[i*8 +: 8]) w_ge = 1'b0;
      outPixel = (w_ge && (refScore != 8'h00)) ? 8'hFF : 8'h00;
   end

   assign outAddr = refAddr - AW'(IMG_W + 1);

endmodule

// File: rtl/nms_line_buffer.sv
// One image row of delay: a DEPTH-entry shift register that advances only
// when i_en is high, so o_dout is the sample pushed DEPTH pushes earlier.
module nms_line_buffer #(
   parameter int DEPTH = 181,
   parameter int DW    = 8
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          i_en,
   input  logic [DW-1:0] i_din,
   output logic [DW-1:0] o_dout
);

   logic [DW-1:0] r_mem [DEPTH];

   // Shift the whole row by one position on every enabled push.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (i_en) begin
         r_mem[0] <= i_din;
         for (int i = 1; i < DEPTH; i++) r_mem[i] <= r_mem[i-1];
      end
   end

   assign o_dout = r_mem[DEPTH-1];

endmodule

// File: rtl/nms_controller.sv
// NMS stage sequencer: streams the score memory in raster order, builds a
// 3x3 window from two line buffers plus two registered columns, asks the
// datapath for a verdict and writes surviving corners through a one-entry
// output register. A one-entry skid holds the returning read while a new
// corner is blocked behind an unaccepted one.
module nms_controller
   import nms_pkg::*;
#(
   parameter int IMG_W = IMG_W_DEF,
   parameter int IMG_H = IMG_H_DEF,
   parameter int AW    = AW_DEF
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic          sc_rd_en,
   output logic [AW-1:0] sc_addr,
   input  logic [7:0]    sc_data,
   output logic          cor_wr_en,
   input  logic          cor_ready,
   output logic [AW-1:0] cor_addr,
   output logic [7:0]    cor_data,
   output logic [AW-1:0] corner_cnt
);

   localparam logic [AW-1:0] LAST_ADDR = AW'(IMG_W * IMG_H - 1);
   localparam logic [AW-1:0] LAST_COL  = AW'(IMG_W - 1);

   nms_state_t    r_state;
   logic          r_busy;
   logic          r_done;
   logic [AW-1:0] r_rd_addr;
   logic          r_rd_vld;
   logic          r_skid_vld;
   logic [7:0]    r_skid;
   logic [AW-1:0] r_pix_addr;
   logic [AW-1:0] r_row;
   logic [AW-1:0] r_col;
   logic [7:0]    r_tl, r_t, r_l, r_c, r_bl, r_b;
   logic          r_out_vld;
   logic [AW-1:0] r_out_addr;
   logic [AW-1:0] r_cnt;

   logic          w_pix_vld;
   logic [7:0]    w_pix;
   logic [7:0]    w_lb1;
   logic [7:0]    w_lb2;
   logic [63:0]   w_adj;
   logic [7:0]    w_dp_pixel;
   logic [AW-1:0] w_dp_addr;
   logic          w_win_vld;
   logic          w_corner;
   logic          w_accept;
   logic          w_stall;
   logic          w_consume;
   logic          w_start;
   logic          w_rd_en;

   // The pending pixel is the skid entry if one is held, else the memory return.
   assign w_pix_vld = r_skid_vld | r_rd_vld;
   assign w_pix     = r_skid_vld ? r_skid : sc_data;

   // (r_row, r_col) is the bottom-right pixel; windows straddling a row wrap
   // or the top two rows never qualify, which also keeps border centres out.
   assign w_win_vld = (r_row >= AW'(2)) && (r_col >= AW'(2));
   assign w_corner  = w_pix_vld && w_win_vld && (w_dp_pixel == 8'hFF);
   assign w_accept  = r_out_vld && cor_ready;
   assign w_stall   = w_corner && r_out_vld && !cor_ready;
   assign w_consume = w_pix_vld && !w_stall;
   assign w_start   = (r_state == IDLE) && start;

   // Reads stop the same cycle a stall appears, so at most one return
   // (the one landing now) ever needs the skid entry.
   assign w_rd_en   = (r_state == RUN) && !w_stall;

   // Pack the window: right column is live (line buffers + incoming pixel).
   always_comb begin
      w_adj = '0;
      w_adj[ADJ_TL*8 +: 8] = r_tl;
      w_adj[ADJ_T*8  +: 8] = r_t;
      w_adj[ADJ_TR*8 +: 8] = w_lb2;
      w_adj[ADJ_L*8  +: 8] = r_l;
      w_adj[ADJ_R*8  +: 8] = w_lb1;
      w_adj[ADJ_BL*8 +: 8] = r_bl;
      w_adj[ADJ_B*8  +: 8] = r_b;
      w_adj[ADJ_BR*8 +: 8] = w_pix;
   end

   nms_line_buffer #(.DEPTH(IMG_W), .DW(8)) u_lb_mid (
      .clk     (clk),
      .reset_n (reset_n),
      .i_en    (w_consume),
      .i_din   (w_pix),
      .o_dout  (w_lb1)
   );

   nms_line_buffer #(.DEPTH(IMG_W), .DW(8)) u_lb_top (
      .clk     (clk),
      .reset_n (reset_n),
      .i_en    (w_consume),
      .i_din   (w_lb1),
      .o_dout  (w_lb2)
   );

   NMS_Datapath #(.IMG_W(IMG_W), .AW(AW)) u_dp (
      .refScore (r_c),
      .adjScore (w_adj),
      .refAddr  (r_pix_addr),
      .outPixel (w_dp_pixel),
      .outAddr  (w_dp_addr)
   );

   // Frame sequencing with registered busy/done.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE:  if (start) begin
                      r_state <= RUN;
                      r_busy  <= 1'b1;
                   end
            RUN:   if (w_rd_en && (r_rd_addr == LAST_ADDR)) r_state <= DRAIN;
            DRAIN: if (!r_rd_vld && !r_skid_vld && !r_out_vld) begin
                      r_state <= DONE;
                      r_done  <= 1'b1;
                   end
            DONE:  begin
                      r_state <= IDLE;
                      r_busy  <= 1'b0;
                   end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Read address generator; the return is valid one cycle after the strobe.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rd_addr <= '0;
         r_rd_vld  <= 1'b0;
      end else begin
         r_rd_vld <= w_rd_en;
         if (w_start)      r_rd_addr <= '0;
         else if (w_rd_en) r_rd_addr <= r_rd_addr + AW'(1);
      end
   end

   // Capture a return that arrives while the window is frozen; release it once the stall clears.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_skid_vld <= 1'b0;
         r_skid     <= '0;
      end else if (!r_skid_vld && r_rd_vld && w_stall) begin
         r_skid_vld <= 1'b1;
         r_skid     <= sc_data;
      end else if (r_skid_vld && !w_stall) begin
         r_skid_vld <= 1'b0;
      end
   end

   // Track the address and row/column of the next pixel entering the window.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pix_addr <= '0;
         r_row      <= '0;
         r_col      <= '0;
      end else if (w_start) begin
         r_pix_addr <= '0;
         r_row      <= '0;
         r_col      <= '0;
      end else if (w_consume) begin
         r_pix_addr <= r_pix_addr + AW'(1);
         if (r_col == LAST_COL) begin
            r_col <= '0;
            r_row <= r_row + AW'(1);
         end else begin
            r_col <= r_col + AW'(1);
         end
      end
   end

   // Shift the two stored window columns left as each pixel is consumed.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_tl <= '0;
         r_t  <= '0;
         r_l  <= '0;
         r_c  <= '0;
         r_bl <= '0;
         r_b  <= '0;
      end else if (w_consume) begin
         r_tl <= r_t;
         r_t  <= w_lb2;
         r_l  <= r_c;
         r_c  <= w_lb1;
         r_bl <= r_b;
         r_b  <= w_pix;
      end
   end

   // Output register: load on a corner (possibly while the previous one is accepted), count accepted writes.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_out_vld  <= 1'b0;
         r_out_addr <= '0;
         r_cnt      <= '0;
      end else begin
         if (w_corner && !w_stall) begin
            r_out_vld  <= 1'b1;
            r_out_addr <= w_dp_addr;
         end else if (w_accept) begin
            r_out_vld <= 1'b0;
         end
         if (w_start)       r_cnt <= '0;
         else if (w_accept) r_cnt <= r_cnt + AW'(1);
      end
   end

   assign busy       = r_busy;
   assign done       = r_done;
   assign sc_rd_en   = w_rd_en;
   assign sc_addr    = r_rd_addr;
   assign cor_wr_en  = r_out_vld;
   assign cor_addr   = r_out_addr;
   assign cor_data   = r_out_vld ? 8'hFF : 8'h00;
   assign corner_cnt = r_cnt;

endmodule

// File: tb/tb_nms_controller.sv
// Self-checking bench for nms_controller on a 40x30 frame.
module tb_nms_controller;

   localparam int W  = 40;
   localparam int H  = 30;
   localparam int AW = 15;
   localparam int N  = W * H;

   logic          clk       = 1'b0;
   logic          reset_n   = 1'b0;
   logic          start     = 1'b0;
   logic          cor_ready = 1'b1;
   logic [7:0]    sc_data   = 8'h00;
   logic          busy, done, sc_rd_en, cor_wr_en;
   logic [AW-1:0] sc_addr, cor_addr, corner_cnt;
   logic [7:0]    cor_data;

   always #5 clk = ~clk;

   nms_controller #(.IMG_W(W), .IMG_H(H), .AW(AW)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .sc_rd_en   (sc_rd_en),
      .sc_addr    (sc_addr),
      .sc_data    (sc_data),
      .cor_wr_en  (cor_wr_en),
      .cor_ready  (cor_ready),
      .cor_addr   (cor_addr),
      .cor_data   (cor_data),
      .corner_cnt (corner_cnt)
   );

   // ---------------- score memory model (1-cycle read latency) ----------------
   logic [7:0] mem [N];
   always @(posedge clk)
      if (sc_rd_en && (int'(sc_addr) < N)) sc_data <= mem[sc_addr];

   // ---------------- corner memory readiness ----------------
   int rmode = 0;
   int cyc   = 0;
   always @(posedge clk) begin
      #1;
      cyc = cyc + 1;
      case (rmode)
         1:       cor_ready = ((cyc % 3) == 0);
         2:       cor_ready = ($urandom_range(0, 1) == 1);
         default: cor_ready = 1'b1;
      endcase
   end

   // ---------------- monitor ----------------
   logic mon_clr = 1'b0;
   int   mon_reads, mon_skip, mon_done, mon_bad_data, mon_done_pend, mon_next;
   int   wr_q[$];
   always @(negedge clk) begin
      if (mon_clr) begin
         mon_reads = 0; mon_skip = 0; mon_done = 0; mon_bad_data = 0;
         mon_done_pend = 0; mon_next = 0;
         wr_q.delete();
      end
      if (reset_n) begin
         if (sc_rd_en) begin
            if (int'(sc_addr) != mon_next) mon_skip++;
            mon_next = int'(sc_addr) + 1;
            mon_reads++;
         end
         if (cor_wr_en && cor_ready) begin
            wr_q.push_back(int'(cor_addr));
            if (cor_data != 8'hFF) mon_bad_data++;
         end
         if (done) begin
            mon_done++;
            if (cor_wr_en) mon_done_pend++;
         end
      end
   end

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference model: every interior pixel with a non-zero score that no
   // neighbour exceeds, listed in raster order.
   int exp_q[$];
   function automatic void build_model();
      exp_q.delete();
      for (int r = 1; r < H - 1; r++)
         for (int c = 1; c < W - 1; c++) begin
            int  s;
            bit  ok;
            s  = int'(mem[r*W + c]);
            ok = (s != 0);
            for (int dr = -1; dr <= 1; dr++)
               for (int dc = -1; dc <= 1; dc++)
                  if ((dr != 0 || dc != 0) && int'(mem[(r+dr)*W + c + dc]) > s) ok = 0;
            if (ok) exp_q.push_back(r*W + c);
         end
   endfunction

   typedef struct packed {
      logic [3:0][7:0] pr, pc, ps;
      logic [1:0]      rmode;
      logic [7:0]      exp_cnt;
      logic [15:0]     exp_first;
   } vec_t;

   function automatic vec_t mk(input int r0, c0, s0, r1, c1, s1, r2, c2, s2,
                               r3, c3, s3, rm, cnt, first);
      vec_t v;
      v.pr[0] = 8'(r0); v.pc[0] = 8'(c0); v.ps[0] = 8'(s0);
      v.pr[1] = 8'(r1); v.pc[1] = 8'(c1); v.ps[1] = 8'(s1);
      v.pr[2] = 8'(r2); v.pc[2] = 8'(c2); v.ps[2] = 8'(s2);
      v.pr[3] = 8'(r3); v.pc[3] = 8'(c3); v.ps[3] = 8'(s3);
      v.rmode     = 2'(rm);
      v.exp_cnt   = 8'(cnt);
      v.exp_first = 16'(first);
      return v;
   endfunction

   task automatic load_vec(input vec_t v);
      for (int i = 0; i < N; i++) mem[i] = 8'h00;
      for (int k = 0; k < 4; k++)
         if (v.ps[k] != 8'h00) mem[int'(v.pr[k])*W + int'(v.pc[k])] = v.ps[k];
      rmode = int'(v.rmode);
      build_model();
   endtask

   task automatic start_frame();
      @(posedge clk);
      #1 start = 1'b1; mon_clr = 1'b1;
      @(posedge clk);
      #1 start = 1'b0; mon_clr = 1'b0;
   endtask

   task automatic wait_done(input string tag, input bit start_on_done);
      bit seen;
      seen = 0;
      for (int k = 0; k < 4*N + 200; k++) begin
         @(negedge clk);
         if (done) begin
            seen = 1;
            if (start_on_done) begin
               start = 1'b1;
               @(posedge clk);
               #1 start = 1'b0;
            end
            break;
         end
      end
      @(negedge clk);
      check({tag, ".done_seen"}, int'(seen), 1);
   endtask

   task automatic check_frame(input string tag);
      check({tag, ".reads"},        mon_reads, N);
      check({tag, ".addr_skips"},   mon_skip, 0);
      check({tag, ".done_pulses"},  mon_done, 1);
      check({tag, ".done_pending"}, mon_done_pend, 0);
      check({tag, ".cor_data"},     mon_bad_data, 0);
      check({tag, ".writes"},       wr_q.size(), exp_q.size());
      for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++)
         check($sformatf("%s.addr%0d", tag, i), wr_q[i], exp_q[i]);
      check({tag, ".corner_cnt"},   int'(corner_cnt), exp_q.size());
      check({tag, ".busy_after"},   int'(busy), 0);
   endtask

   task automatic check_table(input string tag, input vec_t v);
      check({tag, ".tbl_cnt"}, wr_q.size(), int'(v.exp_cnt));
      if (v.exp_cnt != 8'd0)
         check({tag, ".tbl_first"}, (wr_q.size() > 0) ? wr_q[0] : -1, int'(v.exp_first));
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   vec_t vecs[8];

   initial begin
      vecs[0] = mk( 0, 0, 0,   0, 0, 0,   0, 0, 0,   0, 0, 0,  0, 0, 0);
      vecs[1] = mk(10,10,50,   0, 0, 0,   0, 0, 0,   0, 0, 0,  0, 1, 410);
      vecs[2] = mk(20,20,40,  20,21,40,   0, 0, 0,   0, 0, 0,  0, 2, 820);
      vecs[3] = mk( 0, 5,90,   5,39,90,  29,20,90,   0, 0, 0,  0, 0, 0);
      vecs[4] = mk(20,20,40,  20,21,40,   5, 5,70,  25,30,60,  1, 4, 205);
      vecs[5] = mk(20,20,40,  20,21,40,   5, 5,70,  25,30,60,  0, 4, 205);
      vecs[6] = mk( 8, 8,30,   8, 9,31,   0, 0, 0,   0, 0, 0,  0, 1, 329);
      vecs[7] = mk(28,38,77,   1, 1, 5,   0, 0, 0,   0, 0, 0,  1, 2, 41);

      for (int i = 0; i < N; i++) mem[i] = 8'h00;

      // Reset values
      repeat (2) @(negedge clk);
      check("rst.busy",       int'(busy), 0);
      check("rst.done",       int'(done), 0);
      check("rst.sc_rd_en",   int'(sc_rd_en), 0);
      check("rst.sc_addr",    int'(sc_addr), 0);
      check("rst.cor_wr_en",  int'(cor_wr_en), 0);
      check("rst.cor_addr",   int'(cor_addr), 0);
      check("rst.cor_data",   int'(cor_data), 0);
      check("rst.corner_cnt", int'(corner_cnt), 0);
      @(posedge clk);
      #1 reset_n = 1'b1;

      // Table-driven frames
      for (int i = 0; i < 8; i++) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         load_vec(vecs[i]);
         start_frame();
         wait_done(tag, 1'b0);
         check_frame(tag);
         check_table(tag, vecs[i]);
      end

      // Reset in the middle of a frame (after the first corner is written), then rerun
      load_vec(vecs[1]);
      start_frame();
      repeat (500) @(posedge clk);
      #1 reset_n = 1'b0;
      #1;
      check("midrst.busy",       int'(busy), 0);
      check("midrst.done",       int'(done), 0);
      check("midrst.sc_rd_en",   int'(sc_rd_en), 0);
      check("midrst.sc_addr",    int'(sc_addr), 0);
      check("midrst.cor_wr_en",  int'(cor_wr_en), 0);
      check("midrst.corner_cnt", int'(corner_cnt), 0);
      @(posedge clk);
      #1 reset_n = 1'b1;
      start_frame();
      wait_done("rerun", 1'b0);
      check_frame("rerun");
      check_table("rerun", vecs[1]);

      // Start while busy and start coincident with done are both ignored
      load_vec(vecs[4]);
      start_frame();
      repeat (100) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done("ignstart", 1'b1);
      check_frame("ignstart");
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("ignstart.idle%0d", k), int'(busy) + int'(sc_rd_en), 0);
      end

      // Randomised score frames against the reference model
      for (int f = 0; f < 3; f++) begin
         string tag;
         tag = $sformatf("rand%0d", f);
         for (int i = 0; i < N; i++) mem[i] = 8'($urandom_range(0, 3));
         rmode = (f == 0) ? 1 : 2;
         build_model();
         start_frame();
         wait_done(tag, 1'b0);
         check_frame(tag);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
